// File: rtl/pipe_reg_if_id_skid_pkg.sv
// Shared IF/ID skid register types and defaults.
// Perf counters are enabled with PIPE_REG_IF_ID_PERF_CNT_EN.
package pipe_reg_if_id_skid_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          INST_W_DEF   = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RST_PC_DEF   = 32'h0000_0000;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_reg_if_id_skid_skid_buf.sv
// Generic two-entry skid buffer with flush.
// in_ready is a flop that is low exactly while the skid slot is occupied.
module pipe_skid_buf
  import pipe_reg_if_id_skid_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  occ_e              state;
  occ_e              state_n;
  logic              ready_q;
  logic              ready_n;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_n;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_n;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state != OCC_EMPTY);
  assign in_ready  = ready_q;
  assign out_data  = main_q;
  assign in_fire   = in_valid & ready_q;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= OCC_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_n;
      ready_q <= ready_n;
    end
  end

  always_ff @(posedge clk) begin
    main_q <= main_n;
    skid_q <= skid_n;
  end

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush) begin
      state_n = OCC_EMPTY;
    end else begin
      unique case (state)
        OCC_EMPTY: begin
          if (in_fire) begin
            state_n = OCC_ONE;
            main_n  = in_data;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_n = in_data;
          end else if (in_fire) begin
            state_n = OCC_FULL;
            skid_n  = in_data;
          end else if (out_fire) begin
            state_n = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            state_n = OCC_ONE;
            main_n  = skid_q;
          end
        end
        default: state_n = OCC_EMPTY;
      endcase
    end
    ready_n = (state_n != OCC_FULL);
  end

endmodule

// File: rtl/pipe_reg_if_id_skid.sv
// IF/ID pipeline register on a skid buffer with NOP bubble masking.
// Define PIPE_REG_IF_ID_PERF_CNT_EN to add stall/flush counters.
module pipe_reg_if_id_skid
  import pipe_reg_if_id_skid_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
  parameter logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RST_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
`ifdef PIPE_REG_IF_ID_PERF_CNT_EN
  output logic [INST_W-1:0] out_inst,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`else
  output logic [INST_W-1:0] out_inst
`endif
);

  localparam int DATA_W = ADDR_W + INST_W;

  logic [DATA_W-1:0] buf_data;
  logic              buf_valid;

  pipe_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_pc, in_inst}),
    .out_valid (buf_valid),
    .out_ready (out_ready),
    .out_data  (buf_data)
  );

  // Empty slots always present a clean bubble, never stale data.
  assign out_valid = buf_valid;
  assign out_pc    = buf_valid ? buf_data[DATA_W-1:INST_W] : RST_PC;
  assign out_inst  = buf_valid ? buf_data[INST_W-1:0] : NOP_INST;

`ifdef PIPE_REG_IF_ID_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (buf_valid && !out_ready && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (flush && flush_q != '1)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: doc/pipe_reg_if_id_skid.md
Name: pipe_reg_if_id_skid

Overview:
- Parametrised successor of the fixed IF/ID register.
- Decouples fetch from decode with a valid/ready handshake.
- A two-entry skid buffer gives full throughput with a registered in_ready.
- Supports pipeline flush (branch/jump redirect) and emits a canonical NOP bubble on empty or flushed slots.

Parameters:
- ADDR_W, 32, width of PC bus
- INST_W, 32, width of instruction bus
- NOP_INST, 32'h0000_0013, value driven on out_inst when out_valid=0 (addi x0,x0,0)
- RST_PC, 32'h0000_0000, value driven on out_pc when out_valid=0

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries this cycle
- in_valid  in  1  fetch presents pc/inst
- in_ready  out  1  block can accept; registered, equals "skid slot empty"
- in_pc  in  ADDR_W  fetch PC
- in_inst  in  INST_W  fetched instruction
- out_valid  out  1  decode-side entry valid
- out_ready  in  1  decode accepts entry
- out_pc  out  ADDR_W  PC to decode
- out_inst  out  INST_W  instruction to decode

Behaviour:
- Reset (synchronous, active-high; clock clk): out_valid=0, in_ready=1, out_pc=RST_PC, out_inst=NOP_INST, skid slot empty. Reset has priority over flush and all handshakes.
- Storage:
  - main slot drives the outputs directly (registered, no combinational path from in_* to out_*).
  - skid slot holds one overflow entry.
- Transfers:
  - Input fires when in_valid & in_ready.
  - Output fires when out_valid & out_ready.
  - Latency is 1 cycle from input fire to out_valid when main is empty or draining.
- State (encoded by occupancy):
  - EMPTY: main invalid, skid empty.
  - ONE: main valid, skid empty.
  - FULL: main valid, skid valid.
- Transitions:
  - EMPTY + in fire -> ONE (main <= in).
  - ONE + in fire + out fire -> ONE (main <= in).
  - ONE + in fire, no out fire -> FULL (skid <= in, in_ready <= 0).
  - ONE + out fire, no in fire -> EMPTY.
  - FULL + out fire -> ONE (main <= skid, in_ready <= 1). in_ready is 0 in FULL, so no input is accepted.
- in_ready is a flop; it deasserts in the same cycle FULL is entered.
- Flush:
  - Next state EMPTY, in_ready <= 1, outputs revert to RST_PC/NOP_INST.
  - An input firing in the flush cycle is dropped.
  - An output firing in the flush cycle completes normally (decode already sampled it).
- When out_valid=0, out_pc=RST_PC and out_inst=NOP_INST always (never stale data).
- Stable outputs: while out_valid=1 and out_ready=0, out_pc/out_inst hold constant.
- Ordering: entries leave in arrival order; no duplication or loss except on flush.

Optional Feature:
- Macro PIPE_REG_IF_ID_PERF_CNT_EN adds two outputs:
  - stall_cnt[31:0]: cycles with out_valid & ~out_ready.
  - flush_cnt[31:0]: cycles with flush=1.
- Both counters clear on rst and saturate at 32'hFFFF_FFFF.
- Without the macro the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Shared package/defines: ADDR_W/INST_W defaults, NOP_INST encoding, RST_PC, occupancy state encoding (EMPTY/ONE/FULL).
- One natural sub-module: pipe_skid_buf, a generic DATA_W skid buffer with flush.
- This block instantiates pipe_skid_buf with {pc,inst} as payload and adds the NOP/RST_PC output masking plus the optional counters.

Test Plan:
- Reset: assert rst 2 cycles mid-stream -> out_valid=0, in_ready=1, out_inst=32'h13, out_pc=0 on the cycle after rst is sampled.
- Streaming: in_valid=1, out_ready=1, pc 0x0,0x4,0x8 with inst 0xA,0xB,0xC -> out sequence identical, one per cycle, 1-cycle latency, in_ready stays 1.
- Backpressure: out_ready=0 while sending pc 0x10,0x14,0x18 -> 0x10 held on outputs, 0x14 in skid, in_ready=0, 0x18 held by source. Then out_ready=1 -> 0x10,0x14,0x18 in order with no loss.
- Flush while FULL: state FULL (0x20 main, 0x24 skid), flush=1 with in_valid=1 pc 0x28 -> next cycle out_valid=0, out_inst=32'h13, in_ready=1. 0x24 and 0x28 never appear.
- Flush plus output fire: out_ready=1 and flush=1 on the same cycle with 0x30 valid -> 0x30 counted as consumed, then EMPTY.
- PERF_CNT_EN: 5 backpressured cycles plus 2 flush cycles -> stall_cnt=5, flush_cnt=2. Saturation checked by forcing the count to 32'hFFFF_FFFE and stalling 3 cycles -> stall_cnt=32'hFFFF_FFFF.
